// File: rtl/alu_issue_unit.sv
// alu_issue_unit
//   Sequential front end for the combinational ALU. It accepts one request at a
//   time, drives the ALU operand and control inputs, and iterates shifts one bit
//   per cycle by feeding the ALU result back as operand A. The captured result
//   is returned on a valid/ready response channel.
//
// Ports
//   clk, rst_n             clock, asynchronous active-low reset
//   req_valid/req_ready    request handshake; req_ready = (state == IDLE)
//   req_op/req_a/req_b     opcode (0 ADD .. 8 SRA, 9-15 illegal) and operands
//   alu_a/alu_b/alu_op     registered drive to the external combinational ALU
//   alu_result             combinational ALU result
//   rsp_valid/rsp_ready    response handshake
//   rsp_result/rsp_err     captured result, illegal-opcode flag
//   rsp_zero/rsp_neg       result flags, present only when ALU_ISSUE_FLAGS_EN is defined
//
// Configuration macro: ALU_ISSUE_FLAGS_EN adds the rsp_zero/rsp_neg outputs.
module alu_issue_unit #(
  parameter int DATA_WIDTH = 16,
  parameter int SHAMT_W    = $clog2(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [3:0]            req_op,
  input  logic [DATA_WIDTH-1:0] req_a,
  input  logic [DATA_WIDTH-1:0] req_b,
  output logic [DATA_WIDTH-1:0] alu_a,
  output logic [DATA_WIDTH-1:0] alu_b,
  output logic [3:0]            alu_op,
  input  logic [DATA_WIDTH-1:0] alu_result,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_result,
`ifdef ALU_ISSUE_FLAGS_EN
  output logic                  rsp_zero,
  output logic                  rsp_neg,
`endif
  output logic                  rsp_err
);

  typedef enum logic [1:0] {IDLE, EXEC, SHIFT, RESP} state_t;

  state_t                state_q;
  logic [3:0]            op_q;
  logic [SHAMT_W-1:0]    count_q;
  logic [DATA_WIDTH-1:0] acc_q;
  logic [DATA_WIDTH-1:0] alu_a_q, alu_b_q;
  logic [3:0]            alu_op_q;
  logic [DATA_WIDTH-1:0] rsp_result_q;
  logic                  rsp_err_q;
`ifdef ALU_ISSUE_FLAGS_EN
  logic                  rsp_zero_q, rsp_neg_q;
`endif

  // capture-point decode: what goes into the response registers this cycle
  logic                  cap_en, cap_err;
  logic [DATA_WIDTH-1:0] cap_res;

  function automatic logic op_is_shift(input logic [3:0] op);
    return (op == 4'd6) || (op == 4'd7) || (op == 4'd8);
  endfunction

  function automatic logic op_is_legal(input logic [3:0] op);
    return op <= 4'd8;
  endfunction

  always_comb begin
    cap_en  = 1'b0;
    cap_err = 1'b0;
    cap_res = alu_result;
    case (state_q)
      EXEC: begin
        cap_en = 1'b1;
        if (!op_is_legal(op_q)) begin
          cap_res = '0;
          cap_err = 1'b1;
        end else if (op_is_shift(op_q)) begin
          // shift by zero bypasses the ALU
          cap_res = acc_q;
        end
      end
      SHIFT:   cap_en = (count_q == SHAMT_W'(1));
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      op_q         <= '0;
      count_q      <= '0;
      acc_q        <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_op_q     <= '0;
      rsp_result_q <= '0;
      rsp_err_q    <= 1'b0;
`ifdef ALU_ISSUE_FLAGS_EN
      rsp_zero_q   <= 1'b0;
      rsp_neg_q    <= 1'b0;
`endif
    end else begin
      if (cap_en) begin
        rsp_result_q <= cap_res;
        rsp_err_q    <= cap_err;
`ifdef ALU_ISSUE_FLAGS_EN
        rsp_zero_q   <= !cap_err && (cap_res == '0);
        rsp_neg_q    <= !cap_err && cap_res[DATA_WIDTH-1];
`endif
      end
      case (state_q)
        IDLE: if (req_valid) begin
          op_q    <= req_op;
          count_q <= req_b[SHAMT_W-1:0];
          acc_q   <= req_a;
          if (op_is_shift(req_op) && (req_b[SHAMT_W-1:0] != '0)) begin
            state_q  <= SHIFT;
            alu_a_q  <= req_a;
            alu_b_q  <= DATA_WIDTH'(1);
            alu_op_q <= req_op;
          end else begin
            state_q <= EXEC;
            // ALU stays parked for illegal ops and zero-amount shifts
            if (op_is_legal(req_op) && !op_is_shift(req_op)) begin
              alu_a_q  <= req_a;
              alu_b_q  <= req_b;
              alu_op_q <= req_op;
            end
          end
        end
        EXEC: begin
          state_q  <= RESP;
          alu_a_q  <= '0;
          alu_b_q  <= '0;
          alu_op_q <= '0;
        end
        SHIFT: begin
          acc_q   <= alu_result;
          count_q <= count_q - SHAMT_W'(1);
          if (count_q == SHAMT_W'(1)) begin
            state_q  <= RESP;
            alu_a_q  <= '0;
            alu_b_q  <= '0;
            alu_op_q <= '0;
          end else begin
            alu_a_q <= alu_result;
          end
        end
        RESP: if (rsp_ready) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign rsp_valid  = (state_q == RESP);
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_op     = alu_op_q;
  assign rsp_result = rsp_result_q;
  assign rsp_err    = rsp_err_q;
`ifdef ALU_ISSUE_FLAGS_EN
  assign rsp_zero   = rsp_zero_q;
  assign rsp_neg    = rsp_neg_q;
`endif

endmodule

// File: tb/tb_alu_issue_unit.sv
// Bench for alu_issue_unit: a behavioural ALU closes the loop, directed and
// random requests push expected responses into a queue, and a monitor pops and
// compares on every response handshake.
module tb_alu_issue_unit;
  localparam int DW = 16;
  localparam int SW = $clog2(DW);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [3:0]    req_op = '0;
  logic [DW-1:0] req_a = '0, req_b = '0;
  logic [DW-1:0] alu_a, alu_b, alu_result;
  logic [3:0]    alu_op;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_result;
  logic          rsp_err;
`ifdef ALU_ISSUE_FLAGS_EN
  logic          rsp_zero, rsp_neg;
`endif

  alu_issue_unit #(.DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
`ifdef ALU_ISSUE_FLAGS_EN
    .rsp_zero(rsp_zero), .rsp_neg(rsp_neg),
`endif
    .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  // external combinational ALU
  always_comb begin
    alu_result = '0;
    case (alu_op)
      4'd0: alu_result = alu_a + alu_b;
      4'd1: alu_result = alu_a - alu_b;
      4'd2: alu_result = alu_a & alu_b;
      4'd3: alu_result = alu_a | alu_b;
      4'd4: alu_result = alu_a ^ alu_b;
      4'd5: alu_result = ~alu_a;
      4'd6: alu_result = alu_a << alu_b[SW-1:0];
      4'd7: alu_result = alu_a >> alu_b[SW-1:0];
      4'd8: alu_result = DW'($signed(alu_a) >>> alu_b[SW-1:0]);
      default: alu_result = '0;
    endcase
  end

  typedef struct {
    logic [DW-1:0] res;
    logic          err;
    int            acc_cyc;
    int            lat;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0, n_bad = 0;
  int   cyc = 0;
  int   rdy_mode = 1;  // 0 low, 1 high, 2 random

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       rsp_ready = 1'b0;
      1:       rsp_ready = 1'b1;
      default: rsp_ready = ($urandom_range(0, 3) != 0);
    endcase
  end
  initial rsp_ready = 1'b1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // reference: whole-operation semantics, shift amount applied at once
  function automatic exp_t model(input logic [3:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
    exp_t e;
    int   sh;
    sh    = int'(b[SW-1:0]);
    e.err = 1'b0;
    e.lat = 1;
    e.acc_cyc = 0;
    case (op)
      4'd0: e.res = a + b;
      4'd1: e.res = a - b;
      4'd2: e.res = a & b;
      4'd3: e.res = a | b;
      4'd4: e.res = a ^ b;
      4'd5: e.res = ~a;
      4'd6: e.res = a << sh;
      4'd7: e.res = a >> sh;
      4'd8: e.res = DW'($signed(a) >>> sh);
      default: begin e.res = '0; e.err = 1'b1; end
    endcase
    if (op >= 4'd6 && op <= 4'd8 && sh != 0) e.lat = sh;
    return e;
  endfunction

  // monitor
  logic          prev_v = 1'b0;
  int            rise_cyc = 0;
  logic [DW-1:0] hold_res = '0;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_v = 1'b0;
    end else begin
      if (rsp_valid && !prev_v) begin
        rise_cyc = cyc;
        hold_res = rsp_result;
      end
      if (rsp_valid) begin
        chk("req_ready_in_resp", {31'd0, req_ready}, 32'd0);
        if (rsp_ready) begin
          if (q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL unexpected_rsp: got result %0h with no request pending", rsp_result);
          end else begin
            exp_t e;
            e = q.pop_front();
            chk("rsp_result", {16'd0, rsp_result}, {16'd0, e.res});
            chk("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
            chk("latency", rise_cyc - e.acc_cyc, e.lat);
            chk("rsp_stable", {16'd0, rsp_result}, {16'd0, hold_res});
`ifdef ALU_ISSUE_FLAGS_EN
            chk("rsp_zero", {31'd0, rsp_zero}, {31'd0, !e.err && e.res == '0});
            chk("rsp_neg", {31'd0, rsp_neg}, {31'd0, !e.err && e.res[DW-1]});
`endif
          end
        end
      end
      prev_v = rsp_valid;
    end
  end

  task automatic issue(input logic [3:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
    exp_t e;
    int   t = 0;
    while (!req_ready && t < 300) begin @(posedge clk); #1; t++; end
    if (!req_ready) begin
      n_cmp++; n_bad++;
      $display("FAIL ready_timeout: req_ready stayed 0 for %0d cycles", t);
      return;
    end
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_op = 4'($urandom); req_a = DW'($urandom); req_b = DW'($urandom);
    e = model(op, a, b);
    e.acc_cyc = cyc;
    q.push_back(e);
  endtask

  task automatic drain();
    int t = 0;
    while ((q.size() != 0 || !req_ready) && t < 500) begin @(posedge clk); #1; t++; end
    if (q.size() != 0 || !req_ready) begin
      n_cmp++; n_bad++;
      $display("FAIL drain_timeout: %0d responses outstanding", q.size());
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_req_ready"}, {31'd0, req_ready}, 32'd1);
    chk({tag, "_rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
    chk({tag, "_rsp_result"}, {16'd0, rsp_result}, 32'd0);
    chk({tag, "_rsp_err"}, {31'd0, rsp_err}, 32'd0);
    chk({tag, "_alu_drive"}, {alu_op, 12'd0, alu_a | alu_b}, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    chk_reset_vals("reset");
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // directed
    issue(4'd0, 16'h1234, 16'h0001);
    issue(4'd1, 16'h0000, 16'h0001);
    issue(4'd4, 16'hA5A5, 16'hA5A5);
    drain();

    issue(4'd8, 16'h8000, 16'h0004);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("sra_alu_op", {28'd0, alu_op}, 32'd8);
      chk("sra_alu_b", {16'd0, alu_b}, 32'd1);
    end
    @(negedge clk);
    chk("sra_alu_park", {28'd0, alu_op}, 32'd0);
    @(posedge clk); #1;
    issue(4'd6, 16'h0001, 16'd15);
    issue(4'd7, 16'h1234, 16'h0010);
    drain();

    // backpressure with a stray request during the hold
    rdy_mode = 0;
    @(posedge clk); #1;
    issue(4'd2, 16'hFF00, 16'h0F0F);
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin req_valid = 1'b1; req_op = 4'd0; req_a = 16'd7; req_b = 16'd7; end
      else req_valid = 1'b0;
      @(negedge clk);
      if (i > 0) chk("hold_result", {16'd0, rsp_result}, 32'h0F00);
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    rdy_mode = 1;
    drain();

    issue(4'hC, 16'h1111, 16'h2222);
    @(negedge clk);
    chk("illegal_alu_op", {28'd0, alu_op}, 32'd0);
    @(posedge clk); #1;
    drain();

    // reset in the 3rd SHIFT cycle of SLL by 8
    issue(4'd6, 16'h0001, 16'd8);
    @(posedge clk); @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("midreset");
    q.delete();
    @(negedge clk); @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("no_rsp_after_reset", {31'd0, rsp_valid}, 32'd0);
    end
    @(posedge clk); #1;
    issue(4'd0, 16'd2, 16'd3);
    drain();

    // random
    rdy_mode = 2;
    for (int i = 0; i < 200; i++) begin
      logic [3:0] op;
      op = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(9, 15)) : 4'($urandom_range(0, 8));
      issue(op, DW'($urandom), DW'($urandom));
      if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
    end
    drain();
    rdy_mode = 1;
    repeat (3) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
